// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and flush control for an in-order pipeline; a scoreboard shifts one entry per post-ID stage.
// Outputs are combinational from the scoreboard and ID inputs; counters saturate at all-ones.
module pipeline_hazard_ctrl #(
  parameter int REG_NUMBER   = 5,
  parameter int DEPTH        = 3,
  parameter int MEM_LAT      = 1,
  parameter int BRANCH_IN_EX = 0,
  parameter int ZERO_REG     = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_NUMBER-1:0]      id_rs1,
  input  logic [REG_NUMBER-1:0]      id_rs2,
  input  logic                       id_use_rs1,
  input  logic                       id_use_rs2,
  input  logic [REG_NUMBER-1:0]      id_rd,
  input  logic                       id_reg_write,
  input  logic                       id_mem_read,
  input  logic                       branch_taken,
  output logic                       stall,
  output logic                       pc_write,
  output logic                       if_id_write,
  output logic                       flush_if_id,
  output logic [$clog2(DEPTH)-1:0]   fwd_a,
  output logic [$clog2(DEPTH)-1:0]   fwd_b,
  output logic [CNT_WIDTH-1:0]       stall_count,
  output logic [CNT_WIDTH-1:0]       flush_count
);

  localparam int FW = $clog2(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [REG_NUMBER-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_NUMBER-1:0] rs1;
    logic [REG_NUMBER-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
  } entry_t;

  entry_t sb [DEPTH];

  logic load_hit;
  logic branch_q;
  logic squash;

  function automatic logic dep(entry_t p, logic [REG_NUMBER-1:0] s, logic use_s);
    return p.valid && p.reg_write && use_s && (p.rd == s) &&
           ((ZERO_REG == 0) || (p.rd != '0));
  endfunction

  // Only loads still short of their data stage can force a stall.
  always_comb begin
    load_hit = 1'b0;
    for (int j = 0; j < MEM_LAT; j++) begin
      if (sb[j].mem_read &&
          (dep(sb[j], id_rs1, id_use_rs1) || dep(sb[j], id_rs2, id_use_rs2)))
        load_hit = 1'b1;
    end
  end

  always_comb begin
    branch_q    = (branch_taken === 1'b1) && rst;
    stall       = 1'b0;
    flush_if_id = 1'b0;
    squash      = 1'b0;
    if (BRANCH_IN_EX != 0) begin
      // A taken branch in EX kills the ID instruction, so its stall is moot.
      flush_if_id = branch_q && sb[0].valid;
      squash      = flush_if_id;
      stall       = id_valid && load_hit && !flush_if_id;
    end else begin
      stall       = id_valid && load_hit;
      flush_if_id = branch_q && !stall;
    end
  end

  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  // Scan oldest to youngest so the youngest matching producer is selected.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (sb[0].valid && dep(sb[k], sb[0].rs1, sb[0].use_rs1)) fwd_a = FW'(k);
      if (sb[0].valid && dep(sb[k], sb[0].rs2, sb[0].use_rs2)) fwd_b = FW'(k);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) sb[k] <= sb[k-1];
      if (stall || squash) begin
        sb[0] <= '0;
      end else begin
        sb[0].valid     <= id_valid;
        sb[0].rd        <= id_rd;
        sb[0].reg_write <= id_reg_write;
        sb[0].mem_read  <= id_mem_read;
        sb[0].rs1       <= id_rs1;
        sb[0].rs2       <= id_rs2;
        sb[0].use_rs1   <= id_use_rs1;
        sb[0].use_rs2   <= id_use_rs2;
      end
      if (stall && (stall_count != {CNT_WIDTH{1'b1}}))
        stall_count <= stall_count + 1'b1;
      if (flush_if_id && (flush_count != {CNT_WIDTH{1'b1}}))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three configurations share one ID stream and are checked
// against an instruction-level model of the hazard rules, plus directed constant checks.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;

  always #5 clk = ~clk;

  logic        a_st, a_pw, a_iw, a_fl;
  logic [1:0]  a_fa, a_fb;
  logic [15:0] a_sc, a_fc;
  logic        b_st, b_pw, b_iw, b_fl;
  logic [2:0]  b_fa, b_fb;
  logic [15:0] b_sc, b_fc;
  logic        c_st, c_pw, c_iw, c_fl;
  logic [1:0]  c_fa, c_fb;
  logic [3:0]  c_sc, c_fc;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .rst(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .stall(a_st), .pc_write(a_pw), .if_id_write(a_iw), .flush_if_id(a_fl),
    .fwd_a(a_fa), .fwd_b(a_fb), .stall_count(a_sc), .flush_count(a_fc));

  pipeline_hazard_ctrl #(.DEPTH(5), .MEM_LAT(2), .BRANCH_IN_EX(1)) dut_b (
    .clk(clk), .rst(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .stall(b_st), .pc_write(b_pw), .if_id_write(b_iw), .flush_if_id(b_fl),
    .fwd_a(b_fa), .fwd_b(b_fb), .stall_count(b_sc), .flush_count(b_fc));

  pipeline_hazard_ctrl #(.CNT_WIDTH(4)) dut_c (
    .clk(clk), .rst(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .stall(c_st), .pc_write(c_pw), .if_id_write(c_iw), .flush_if_id(c_fl),
    .fwd_a(c_fa), .fwd_b(c_fb), .stall_count(c_sc), .flush_count(c_fc));

  // Reference model: per configuration, the instructions occupying each post-ID stage.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
  } ins_t;

  int   cfg_depth [3] = '{3, 5, 3};
  int   cfg_lat   [3] = '{1, 2, 1};
  int   cfg_bex   [3] = '{0, 1, 0};
  int   cfg_cw    [3] = '{16, 16, 4};

  ins_t pipe [3][8];
  int   m_sc [3];
  int   m_fc [3];
  bit   e_st [3];
  bit   e_fl [3];
  int   e_fa [3];
  int   e_fb [3];

  int tests  = 0;
  int failed = 0;

  function automatic bit produces(ins_t p, int r, bit u);
    return p.v && p.rw && u && (p.rd == r) && (r != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) pipe[i][k] = '{default: 0};
      m_sc[i] = 0;
      m_fc[i] = 0;
    end
  endtask

  task automatic model_eval();
    bit bt;
    bit ls;
    bt = (branch_taken === 1'b1) && (rst_n === 1'b1);
    for (int i = 0; i < 3; i++) begin
      ls = 0;
      if (id_valid)
        for (int j = 0; j < cfg_lat[i]; j++)
          if (pipe[i][j].mr && (produces(pipe[i][j], int'(id_rs1), id_use_rs1) ||
                                produces(pipe[i][j], int'(id_rs2), id_use_rs2)))
            ls = 1;
      if (cfg_bex[i] != 0) begin
        e_fl[i] = bt && pipe[i][0].v;
        e_st[i] = ls && !e_fl[i];
      end else begin
        e_st[i] = ls;
        e_fl[i] = bt && !ls;
      end
      e_fa[i] = 0;
      e_fb[i] = 0;
      if (pipe[i][0].v)
        for (int k = 1; k < cfg_depth[i]; k++) begin
          if (e_fa[i] == 0 && produces(pipe[i][k], pipe[i][0].rs1, pipe[i][0].u1)) e_fa[i] = k;
          if (e_fb[i] == 0 && produces(pipe[i][k], pipe[i][0].rs2, pipe[i][0].u2)) e_fb[i] = k;
        end
    end
  endtask

  task automatic model_clock();
    int top;
    if (rst_n !== 1'b1) return;
    for (int i = 0; i < 3; i++) begin
      top = (1 << cfg_cw[i]) - 1;
      if (e_st[i] && m_sc[i] < top) m_sc[i]++;
      if (e_fl[i] && m_fc[i] < top) m_fc[i]++;
      for (int k = cfg_depth[i] - 1; k >= 1; k--) pipe[i][k] = pipe[i][k-1];
      if (e_st[i] || (cfg_bex[i] != 0 && e_fl[i]))
        pipe[i][0] = '{default: 0};
      else
        pipe[i][0] = '{v: id_valid, rd: int'(id_rd), rw: id_reg_write, mr: id_mem_read,
                       rs1: int'(id_rs1), rs2: int'(id_rs2), u1: id_use_rs1, u2: id_use_rs2};
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input int i, input int st, input int pw, input int iw,
                          input int fl, input int fa, input int fb, input int sc, input int fc);
    chk({tag, "/stall"}, st, int'(e_st[i]));
    chk({tag, "/pc_write"}, pw, int'(!e_st[i]));
    chk({tag, "/if_id_write"}, iw, int'(!e_st[i]));
    chk({tag, "/flush"}, fl, int'(e_fl[i]));
    chk({tag, "/fwd_a"}, fa, e_fa[i]);
    chk({tag, "/fwd_b"}, fb, e_fb[i]);
    chk({tag, "/stall_count"}, sc, m_sc[i]);
    chk({tag, "/flush_count"}, fc, m_fc[i]);
  endtask

  task automatic check_all(input string tag);
    model_eval();
    chk_inst({tag, ":a"}, 0, a_st, a_pw, a_iw, a_fl, a_fa, a_fb, a_sc, a_fc);
    chk_inst({tag, ":b"}, 1, b_st, b_pw, b_iw, b_fl, b_fa, b_fb, b_sc, b_fc);
    chk_inst({tag, ":c"}, 2, c_st, c_pw, c_iw, c_fl, c_fa, c_fb, c_sc, c_fc);
  endtask

  // Called just after a falling edge with inputs applied; settles, then checks.
  task automatic settle(input string tag);
    #1;
    check_all(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rd, input bit rw, input bit mr,
                        input int rs1, input bit u1, input int rs2, input bit u2, input bit bt);
    id_valid = v; id_rd = 5'(rd); id_reg_write = rw; id_mem_read = mr;
    id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2; branch_taken = bt;
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) begin
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle("idle");
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    settle("reset");
    chk("reset_pc_write", a_pw, 1);
    advance();
    rst_n = 1'b1;
    idle(2);

    // Load-use: lw x3 ; add x4,x3,x5
    set_id(1, 3, 1, 1, 0, 0, 0, 0, 0); settle("ld");   advance();
    set_id(1, 4, 1, 0, 3, 1, 5, 1, 0); settle("use1");
    chk("lu_a_stall", a_st, 1); chk("lu_a_pc_write", a_pw, 0); chk("lu_b_stall", b_st, 1);
    advance();
    settle("use2");
    chk("lu_a_stall_done", a_st, 0); chk("lu_b_stall2", b_st, 1);
    advance();
    settle("use3");
    chk("lu_a_fwd_wb", a_fa, 2); chk("lu_a_stall_count", a_sc, 1); chk("lu_b_stall_end", b_st, 0);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("use4");
    chk("lu_b_fwd3", b_fa, 3); chk("lu_b_stall_count", b_sc, 2);
    advance();
    idle(6);

    // Back-to-back ALU forwarding, then with one unrelated instruction between.
    set_id(1, 3, 1, 0, 1, 1, 2, 1, 0); settle("add"); advance();
    set_id(1, 6, 1, 0, 3, 1, 3, 1, 0); settle("sub"); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("fw1");
    chk("fw1_a", a_fa, 1); chk("fw1_b", a_fb, 1);
    advance();
    set_id(1, 3, 1, 0, 1, 1, 2, 1, 0); settle("add"); advance();
    set_id(1, 9, 1, 0, 10, 1, 11, 1, 0); settle("mid"); advance();
    set_id(1, 6, 1, 0, 3, 1, 3, 1, 0); settle("sub"); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("fw2");
    chk("fw2_a", a_fa, 2); chk("fw2_b", a_fb, 2);
    advance();

    // Two writers of x7: youngest wins; writer of x0 never forwards.
    set_id(1, 7, 1, 0, 0, 0, 0, 0, 0); settle("w7a"); advance();
    set_id(1, 7, 1, 0, 0, 0, 0, 0, 0); settle("w7b"); advance();
    set_id(1, 8, 1, 0, 7, 1, 0, 0, 0); settle("r7");  advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("yw");
    chk("youngest_fwd_a", a_fa, 1); chk("youngest_b_fwd_a", b_fa, 1);
    advance();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0); settle("w0");  advance();
    set_id(1, 8, 1, 0, 0, 1, 0, 0, 0); settle("r0");  advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("x0");
    chk("zero_reg_fwd_a", a_fa, 0);
    advance();
    idle(6);

    // Taken branch while a load-use stall is pending.
    set_id(1, 3, 1, 1, 0, 0, 0, 0, 0); settle("bld"); advance();
    set_id(1, 0, 0, 0, 3, 1, 0, 0, 1); settle("br1");
    chk("br_a_stall", a_st, 1); chk("br_a_flush_held", a_fl, 0);
    chk("br_b_stall_forced0", b_st, 0); chk("br_b_flush", b_fl, 1);
    advance();
    settle("br2");
    chk("br_a_flush", a_fl, 1);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("br3");
    chk("br_a_flush_count", a_fc, 1);
    advance();
    idle(6);

    // Repeated load-use pairs drive the 4-bit counter into saturation.
    for (int n = 0; n < 20; n++) begin
      set_id(1, 3, 1, 1, 0, 0, 0, 0, 0); settle("sld"); advance();
      set_id(1, 4, 1, 0, 3, 1, 0, 0, 0); settle("su1"); advance();
      settle("su2"); advance();
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("sat");
    chk("sat_c_stall_count", c_sc, 15); chk("sat_a_stall_count", a_sc, 22);
    advance();

    // Randomized instruction stream over a small register set.
    for (int n = 0; n < 1500; n++) begin
      bit mr;
      mr = ($urandom_range(0, 2) == 0);
      set_id($urandom_range(0, 4) != 0, $urandom_range(0, 3), mr || ($urandom_range(0, 3) != 0), mr,
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 40) == 0) branch_taken = 1'bx;
      settle("rnd");
      advance();
    end
    idle(6);

    // Asynchronous reset in the middle of a stall.
    set_id(1, 3, 1, 1, 0, 0, 0, 0, 0); settle("rld"); advance();
    set_id(1, 4, 1, 0, 3, 1, 0, 0, 1); settle("rst_pre");
    chk("rst_pre_stall", a_st, 1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    chk("rst_a_stall", a_st, 0); chk("rst_a_count", a_sc, 0); chk("rst_a_flush", a_fl, 0);
    advance();
    rst_n = 1'b1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
